// File: rtl/mano_io_unit.sv
// mano_io_unit
//   Mano-style I/O stage that sits beside the CPU datapath. It holds the INPR/FGI input
//   port, which is refilled from a small input FIFO fed by an external byte producer. It
//   also holds the OUTR/FGO output port, which drains to an external consumer, plus the
//   IEN interrupt enable and the interrupt flip-flop R.
//
// Ports
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   in_data/valid/ready producer -> input FIFO handshake
//   out_data/valid/rdy  OUTR -> consumer handshake (out_valid = !FGO)
//   inp,out,ski,sko,    one-cycle I/O instruction strobes from the control unit
//   ion,iof
//   int_ack             interrupt cycle taken: clears R and IEN
//   fetch_busy          CPU in T0..T2; blocks setting R
//   ac_in               AC value written into OUTR on OUT
//   inpr_out            current INPR contents
//   skip                (ski & FGI) | (sko & FGO)
//   fgi, fgo, ien, irq  architectural flags
//   in_ovr, out_ovr     sticky misuse flags (INP while FGI=0, OUT while FGO=0)
module mano_io_unit #(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned IN_FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              inp,
   input  logic              out,
   input  logic              ski,
   input  logic              sko,
   input  logic              ion,
   input  logic              iof,
   input  logic              int_ack,
   input  logic              fetch_busy,
   input  logic [DATA_W-1:0] ac_in,
   output logic [DATA_W-1:0] inpr_out,
   output logic              skip,
   output logic              fgi,
   output logic              fgo,
   output logic              ien,
   output logic              irq,
   output logic              in_ovr,
   output logic              out_ovr
);

   localparam int unsigned PTR_W = (IN_FIFO_DEPTH > 1) ? $clog2(IN_FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] fifo_mem [IN_FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] inpr;
   logic [DATA_W-1:0] outr;

   assign fifo_full  = (count == CNT_W'(IN_FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   // in_ready looks only at full; a same-cycle refill pop does not open a slot early.
   assign in_ready   = !fifo_full && !rst;
   assign push       = in_valid && in_ready;
   // Refill INPR whenever the CPU has consumed it (FGI low) and a byte is waiting.
   assign pop        = !fgi && !fifo_empty;

   assign inpr_out  = inpr;
   assign out_data  = outr;
   assign out_valid = !fgo;
   assign skip      = (ski && fgi) || (sko && fgo);

   // Storage has no reset: contents are dead once the pointers and count reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Depth is a power of two, so pointer wrap is natural overflow.
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Input port: refill and INP are mutually exclusive because pop needs FGI=0
   // while an effective INP needs FGI=1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inpr   <= '0;
         fgi    <= 1'b0;
         in_ovr <= 1'b0;
      end else begin
         if (pop) begin
            inpr <= fifo_mem[rd_ptr];
            fgi  <= 1'b1;
         end else if (inp && fgi) begin
            fgi <= 1'b0;
         end
         if (inp && !fgi) begin
            in_ovr <= 1'b1;
         end
      end
   end

   // Output port: OUT acts only on the registered FGO=1; a handshake on the same edge
   // sees FGO=0, so the OUT is dropped and flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outr    <= '0;
         fgo     <= 1'b1;
         out_ovr <= 1'b0;
      end else begin
         if (out && fgo) begin
            outr <= ac_in;
            fgo  <= 1'b0;
         end else if (!fgo && out_ready) begin
            fgo <= 1'b1;
         end
         if (out && !fgo) begin
            out_ovr <= 1'b1;
         end
      end
   end

   // Interrupt enable and R flip-flop; int_ack has top priority for both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ien <= 1'b0;
         irq <= 1'b0;
      end else begin
         if (int_ack) begin
            ien <= 1'b0;
         end else if (iof) begin
            ien <= 1'b0;
         end else if (ion) begin
            ien <= 1'b1;
         end

         if (int_ack) begin
            irq <= 1'b0;
         end else if (ien && (fgi || fgo) && !fetch_busy) begin
            irq <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mano_io_unit.sv
// tb_mano_io_unit
//   Directed scenarios plus a randomized run against a queue-based reference model of
//   the I/O stage.
module tb_mano_io_unit;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          inp, out, ski, sko, ion, iof, int_ack, fetch_busy;
   logic [DW-1:0] ac_in;
   logic [DW-1:0] inpr_out;
   logic          skip, fgi, fgo, ien, irq, in_ovr, out_ovr;

   int n_checks = 0;
   int n_bad    = 0;

   // Reference model state
   logic [DW-1:0] m_q [$];
   logic [DW-1:0] m_inpr, m_outr;
   logic          m_fgi, m_fgo, m_ien, m_r, m_in_ovr, m_out_ovr;

   mano_io_unit #(.DATA_W(DW), .IN_FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .inp(inp), .out(out), .ski(ski), .sko(sko), .ion(ion), .iof(iof),
      .int_ack(int_ack), .fetch_busy(fetch_busy), .ac_in(ac_in), .inpr_out(inpr_out),
      .skip(skip), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq),
      .in_ovr(in_ovr), .out_ovr(out_ovr)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_q.delete();
      m_inpr = '0; m_outr = '0;
      m_fgi = 1'b0; m_fgo = 1'b1; m_ien = 1'b0; m_r = 1'b0;
      m_in_ovr = 1'b0; m_out_ovr = 1'b0;
   endtask

   // One clock edge of the architectural rules, computed from pre-edge values.
   task automatic model_edge();
      logic          n_fgi, n_fgo, n_ien, n_r;
      logic [DW-1:0] n_inpr, n_outr;
      bit            do_push;
      if (rst) return;
      do_push = in_valid && (m_q.size() < DEPTH);
      n_inpr = m_inpr; n_fgi = m_fgi; n_outr = m_outr; n_fgo = m_fgo;
      if (!m_fgi && m_q.size() > 0) begin
         n_inpr = m_q.pop_front();
         n_fgi  = 1'b1;
      end
      if (inp && m_fgi) n_fgi = 1'b0;
      if (inp && !m_fgi) m_in_ovr = 1'b1;
      if (do_push) m_q.push_back(in_data);
      if (out && m_fgo) begin
         n_outr = ac_in;
         n_fgo  = 1'b0;
      end
      if (out && !m_fgo) m_out_ovr = 1'b1;
      if (!m_fgo && out_ready) n_fgo = 1'b1;
      n_ien = int_ack ? 1'b0 : iof ? 1'b0 : ion ? 1'b1 : m_ien;
      n_r   = int_ack ? 1'b0 : (m_ien && (m_fgi || m_fgo) && !fetch_busy) ? 1'b1 : m_r;
      m_inpr = n_inpr; m_fgi = n_fgi; m_outr = n_outr; m_fgo = n_fgo;
      m_ien = n_ien; m_r = n_r;
   endtask

   // Advance one clock; strobes and in_valid are one-shot.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      {inp, out, ski, sko, ion, iof, int_ack, in_valid} = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({fgo, fgi, ien, irq, out_valid, in_ready, in_ovr, out_ovr} !== 8'b1000_0000) begin
         n_bad++;
         $display("FAIL reset_flags: got fgo,fgi,ien,irq,ov,ir,iovr,oovr=%b want 10000000",
                  {fgo, fgi, ien, irq, out_valid, in_ready, in_ovr, out_ovr});
      end
      n_checks++;
      if ({inpr_out, out_data} !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_data: got inpr=%h outr=%h want 00 00", inpr_out, out_data);
      end
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_input_path();
      do_reset();
      in_valid = 1'b1; in_data = 8'h3C;
      tick();
      n_checks++;
      if (fgi !== 1'b0) begin
         n_bad++;
         $display("FAIL in_latency_early: fgi=%b want 0", fgi);
      end
      in_valid = 1'b1; in_data = 8'h5A;
      tick();
      n_checks++;
      if (fgi !== 1'b1 || inpr_out !== 8'h3C) begin
         n_bad++;
         $display("FAIL in_first: fgi=%b inpr=%h want 1 3c", fgi, inpr_out);
      end
      inp = 1'b1;
      tick();
      n_checks++;
      if (fgi !== 1'b0 || inpr_out !== 8'h3C) begin
         n_bad++;
         $display("FAIL in_after_inp: fgi=%b inpr=%h want 0 3c", fgi, inpr_out);
      end
      tick();
      n_checks++;
      if (fgi !== 1'b1 || inpr_out !== 8'h5A) begin
         n_bad++;
         $display("FAIL in_second: fgi=%b inpr=%h want 1 5a", fgi, inpr_out);
      end
   endtask

   task automatic test_fifo_full();
      logic [DW-1:0] bytes [5];
      do_reset();
      for (int k = 0; k < 5; k++) begin
         bytes[k] = DW'($urandom);
         in_valid = 1'b1; in_data = bytes[k];
         tick();
      end
      n_checks++;
      if (in_ready !== 1'b0 || inpr_out !== bytes[0] || fgi !== 1'b1) begin
         n_bad++;
         $display("FAIL fifo_full: ready=%b inpr=%h fgi=%b want 0 %h 1",
                  in_ready, inpr_out, fgi, bytes[0]);
      end
      for (int k = 1; k < 5; k++) begin
         inp = 1'b1;
         tick();
         tick();
         n_checks++;
         if (inpr_out !== bytes[k] || fgi !== 1'b1) begin
            n_bad++;
            $display("FAIL fifo_drain_%0d: inpr=%h fgi=%b want %h 1", k, inpr_out, fgi,
                     bytes[k]);
         end
      end
      n_checks++;
      if (in_ready !== 1'b1 || in_ovr !== 1'b0) begin
         n_bad++;
         $display("FAIL fifo_drained: ready=%b in_ovr=%b want 1 0", in_ready, in_ovr);
      end
      inp = 1'b1;
      tick();
      inp = 1'b1;
      tick();
      n_checks++;
      if (in_ovr !== 1'b1 || inpr_out !== bytes[4]) begin
         n_bad++;
         $display("FAIL in_ovr: in_ovr=%b inpr=%h want 1 %h", in_ovr, inpr_out, bytes[4]);
      end
   endtask

   task automatic test_output();
      do_reset();
      out_ready = 1'b0;
      ac_in = 8'hA7; out = 1'b1;
      tick();
      n_checks++;
      if (out_data !== 8'hA7 || out_valid !== 1'b1 || fgo !== 1'b0) begin
         n_bad++;
         $display("FAIL out_first: data=%h valid=%b fgo=%b want a7 1 0",
                  out_data, out_valid, fgo);
      end
      ac_in = 8'h11; out = 1'b1;
      tick();
      n_checks++;
      if (out_data !== 8'hA7 || out_ovr !== 1'b1 || fgo !== 1'b0) begin
         n_bad++;
         $display("FAIL out_ovr: data=%h ovr=%b fgo=%b want a7 1 0", out_data, out_ovr, fgo);
      end
      out_ready = 1'b1;
      ac_in = 8'h22; out = 1'b1;
      tick();
      n_checks++;
      if (fgo !== 1'b1 || out_data !== 8'hA7) begin
         n_bad++;
         $display("FAIL out_handshake: fgo=%b data=%h want 1 a7", fgo, out_data);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_interrupt();
      do_reset();
      fetch_busy = 1'b1; ion = 1'b1;
      tick();
      tick();
      n_checks++;
      if (ien !== 1'b1 || irq !== 1'b0) begin
         n_bad++;
         $display("FAIL irq_blocked: ien=%b irq=%b want 1 0", ien, irq);
      end
      fetch_busy = 1'b0;
      tick();
      n_checks++;
      if (irq !== 1'b1) begin
         n_bad++;
         $display("FAIL irq_set: irq=%b want 1", irq);
      end
      int_ack = 1'b1; ion = 1'b1;
      tick();
      n_checks++;
      if (irq !== 1'b0 || ien !== 1'b0) begin
         n_bad++;
         $display("FAIL int_ack: irq=%b ien=%b want 0 0", irq, ien);
      end
      ion = 1'b1;
      tick();
      ion = 1'b1; iof = 1'b1;
      tick();
      n_checks++;
      if (ien !== 1'b0) begin
         n_bad++;
         $display("FAIL ion_iof: ien=%b want 0", ien);
      end
   endtask

   task automatic test_skip_and_reset();
      do_reset();
      in_valid = 1'b1; in_data = 8'h77;
      tick();
      tick();
      ski = 1'b1;
      #1;
      n_checks++;
      if (skip !== 1'b1) begin
         n_bad++;
         $display("FAIL ski_fgi: skip=%b want 1", skip);
      end
      ski = 1'b0;
      out = 1'b1; ac_in = 8'h55;
      tick();
      sko = 1'b1;
      #1;
      n_checks++;
      if (skip !== 1'b0) begin
         n_bad++;
         $display("FAIL sko_fgo0: skip=%b want 0", skip);
      end
      sko = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = DW'(8'h90 + k);
         tick();
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (fgi !== 1'b0 || fgo !== 1'b1 || in_ready !== 1'b0 || inpr_out !== 8'h00) begin
         n_bad++;
         $display("FAIL midop_reset: fgi=%b fgo=%b ready=%b inpr=%h want 0 1 0 00",
                  fgi, fgo, in_ready, inpr_out);
      end
      tick();
      rst = 1'b0;
      #1;
      tick();
      tick();
      n_checks++;
      if (fgi !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL fifo_discarded: fgi=%b ready=%b want 0 1", fgi, in_ready);
      end
   endtask

   task automatic test_random();
      logic [25:0] got, exp;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rst        = ($urandom_range(0, 199) == 0);
         in_valid   = $urandom_range(0, 1) == 1;
         in_data    = DW'($urandom);
         out_ready  = $urandom_range(0, 2) == 0;
         fetch_busy = $urandom_range(0, 1) == 1;
         ac_in      = DW'($urandom);
         inp        = $urandom_range(0, 3) == 0;
         out        = $urandom_range(0, 3) == 0;
         ski        = $urandom_range(0, 2) == 0;
         sko        = $urandom_range(0, 2) == 0;
         ion        = $urandom_range(0, 5) == 0;
         iof        = $urandom_range(0, 9) == 0;
         int_ack    = $urandom_range(0, 7) == 0;
         if (rst) model_reset();
         #1;
         got = {inpr_out, out_data, fgi, fgo, out_valid, ien, irq, in_ready, in_ovr, out_ovr,
                skip, 1'b0};
         exp = {m_inpr, m_outr, m_fgi, m_fgo, !m_fgo, m_ien, m_r,
                (!rst && m_q.size() < DEPTH), m_in_ovr, m_out_ovr,
                ((ski && m_fgi) || (sko && m_fgo)), 1'b0};
         n_checks++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL random_cycle_%0d: got=%h want=%h", i, got, exp);
         end
         tick();
         rst = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      in_data = '0; ac_in = '0;
      {inp, out, ski, sko, ion, iof, int_ack, in_valid} = '0;
      out_ready = 1'b0; fetch_busy = 1'b0;
      test_reset();
      test_input_path();
      test_fifo_full();
      test_output();
      test_interrupt();
      test_skip_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
